// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch and next-PC stage that sits directly in front of the main
// decoder. The unit holds the PC and fetches one instruction word at a time
// over a simple request/ready memory handshake, which may insert any number of
// wait states. It presents the latched word to the decoder and datapath for an
// execute window, then resolves the next PC from the decoder controls and the
// ALU flags.
//
// Sequence of states:
//   IDLE  -> one cycle after reset
//   FETCH -> request pc until memory answers with imem_ready
//   EXEC  -> instruction executes; retires on the first cycle with stall low
//   HALT  -> parked until reset
// An instruction therefore costs at least two cycles: FETCH with imem_ready
// high, then one EXEC cycle.
//
// Parameter:
//   RESET_PC      PC loaded on reset (word aligned)
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   imem_req      fetch request (high in FETCH)
//   imem_addr     fetch address, always equal to pc
//   imem_ready    imem_rdata carries the requested word this cycle
//   imem_rdata    fetched instruction word
//   instr         latched instruction for the decoder/datapath
//   instr_valid   instr is executing this cycle (high in EXEC)
//   stall         hold the current instruction in execute
//   halt_req      enter HALT once the current instruction retires
//   branch        3-bit branch code: 001 beq, 010 bne, 011 bgez,
//                 100 bgtz, 101 blez, 110 bltz (000/111 never taken)
//   jcntrl        j or jal
//   jrcntrl       jr (highest priority target: rs_data)
//   jalcntrl      jal; only qualifies link_addr use downstream
//   alu_zero      ALU result equals zero
//   alu_neg       ALU result bit 31
//   rs_data       register rs value (jr target)
//   pc            current PC
//   link_addr     pc + 4, the jal return address
//   pc_write      pc is updated at this clock edge
//   halted        unit is in HALT
//   fault         misaligned jr seen (sticky until reset)
//
// Build option:
//   JR_ALIGN_CHECK_EN  when defined, a jr whose target has nonzero low bits
//                      does not retire: pc holds, fault is set and the unit
//                      halts, even if stall is high. When undefined, fault is
//                      tied low and the jr target is used unmodified.
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        halt_req,
  input  logic [2:0]  branch,
  input  logic        jcntrl,
  input  logic        jrcntrl,
  input  logic        jalcntrl,
  input  logic        alu_zero,
  input  logic        alu_neg,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        pc_write,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BGEZ = 3'b011;
  localparam logic [2:0] BR_BGTZ = 3'b100;
  localparam logic [2:0] BR_BLEZ = 3'b101;
  localparam logic [2:0] BR_BLTZ = 3'b110;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;

  // Next-PC datapath
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        branch_taken;
  logic [31:0] next_pc;
  logic        jr_misaligned;

  // jalcntrl carries no work here: the jump itself comes from jcntrl and the
  // link address is always available. Kept as a port for the decoder wiring.
  logic unused_jal;
  assign unused_jal = jalcntrl;

  // All adds are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to zero.
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign br_target = pc_plus4 + br_offset;
  assign j_target  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  always_comb begin
    branch_taken = 1'b0;
    unique case (branch)
      BR_BEQ:  branch_taken = alu_zero;
      BR_BNE:  branch_taken = !alu_zero;
      BR_BGEZ: branch_taken = !alu_neg;
      BR_BGTZ: branch_taken = !alu_neg && !alu_zero;
      BR_BLEZ: branch_taken = alu_neg || alu_zero;
      BR_BLTZ: branch_taken = alu_neg;
      default: branch_taken = 1'b0;
    endcase
  end

  // jr beats j/jal, which beat a taken branch, which beats fall-through.
  always_comb begin
    if (jrcntrl) begin
      next_pc = rs_data;
    end else if (jcntrl) begin
      next_pc = j_target;
    end else if (branch_taken) begin
      next_pc = br_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

`ifdef JR_ALIGN_CHECK_EN
  logic fault_q, fault_d;

  assign jr_misaligned = jrcntrl && (rs_data[1:0] != 2'b00);
  assign fault         = fault_q;
`else
  assign jr_misaligned = 1'b0;
  assign fault         = 1'b0;
`endif

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    pc_write    = 1'b0;
    halted      = 1'b0;
`ifdef JR_ALIGN_CHECK_EN
    fault_d     = fault_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        instr_valid = 1'b1;
        if (jr_misaligned) begin
          // Faulting jr never retires and overrides stall.
`ifdef JR_ALIGN_CHECK_EN
          fault_d = 1'b1;
`endif
          state_d = S_HALT;
        end else if (!stall) begin
          // Stall has precedence over halt_req; the halt only lands on the
          // edge where the instruction actually retires.
          pc_write = 1'b1;
          pc_d     = next_pc;
          state_d  = halt_req ? S_HALT : S_FETCH;
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
`ifdef JR_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef JR_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign link_addr = pc_plus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Bench for fetch_pc_unit (RESET_PC = 0x40). A behavioural model follows the
// unit's mode, pc, latched instruction and fault flag from the plain rules of
// the fetch/execute sequence and is compared against every DUT output on every
// falling edge. Directed scenarios add hand-computed literal checks, then a
// randomized phase exercises wait states, stalls, halts, resets and all
// next-PC sources. Honors JR_ALIGN_CHECK_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        halt_req;
  logic [2:0]  branch;
  logic        jcntrl;
  logic        jrcntrl;
  logic        jalcntrl;
  logic        alu_zero;
  logic        alu_neg;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        pc_write;
  logic        halted;
  logic        fault;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .stall      (stall),
    .halt_req   (halt_req),
    .branch     (branch),
    .jcntrl     (jcntrl),
    .jrcntrl    (jrcntrl),
    .jalcntrl   (jalcntrl),
    .alu_zero   (alu_zero),
    .alu_neg    (alu_neg),
    .rs_data    (rs_data),
    .pc         (pc),
    .link_addr  (link_addr),
    .pc_write   (pc_write),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  localparam int MB = 0;  // boot cycle after reset
  localparam int MF = 1;  // waiting for memory
  localparam int ME = 2;  // executing
  localparam int MH = 3;  // parked

  int          m_mode  = MB;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  bit          m_fault = 1'b0;
  bit          live    = 1'b0;

  function automatic logic [31:0] model_next_pc(
      input logic [31:0] p, input logic [31:0] ins, input logic [2:0] br,
      input logic j, input logic jr, input logic z, input logic n,
      input logic [31:0] rs);
    logic [31:0] seq;
    logic [15:0] imm16;
    int          imm;
    bit          take;
    seq   = p + 32'd4;
    imm16 = ins[15:0];
    imm   = int'($signed(imm16));
    if (jr) return rs;
    if (j)  return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    case (br)
      3'd1:    take = z;
      3'd2:    take = !z;
      3'd3:    take = !n;
      3'd4:    take = !n && !z;
      3'd5:    take = n || z;
      3'd6:    take = n;
      default: take = 1'b0;
    endcase
    return take ? seq + 32'(imm * 4) : seq;
  endfunction

  function automatic bit bad_jr(input logic jr, input logic [31:0] rs);
`ifdef JR_ALIGN_CHECK_EN
    return jr && (rs[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Compare on every falling edge, then advance the model to the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        chk("imem_req",    imem_req,    32'(m_mode == MF));
        chk("imem_addr",   imem_addr,   m_pc);
        chk("instr_valid", instr_valid, 32'(m_mode == ME));
        chk("instr",       instr,       m_instr);
        chk("pc",          pc,          m_pc);
        chk("link_addr",   link_addr,   m_pc + 32'd4);
        chk("pc_write",    pc_write,
            32'(m_mode == ME && !stall && !bad_jr(jrcntrl, rs_data)));
        chk("halted",      halted,      32'(m_mode == MH));
        chk("fault",       fault,       32'(m_fault));
      end
      if (rst === 1'b1) begin
        live    = 1'b1;
        m_mode  = MB;
        m_pc    = RST_PC;
        m_instr = '0;
        m_fault = 1'b0;
      end else if (live) begin
        if (m_mode == MB) begin
          m_mode = MF;
        end else if (m_mode == MF) begin
          if (imem_ready) begin
            m_instr = imem_rdata;
            m_mode  = ME;
          end
        end else if (m_mode == ME) begin
          if (bad_jr(jrcntrl, rs_data)) begin
            m_fault = 1'b1;
            m_mode  = MH;
          end else if (!stall) begin
            m_pc   = model_next_pc(m_pc, m_instr, branch, jcntrl, jrcntrl,
                                   alu_zero, alu_neg, rs_data);
            m_mode = halt_req ? MH : MF;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_ctrl();
    stall    = 1'b0;
    halt_req = 1'b0;
    branch   = 3'b000;
    jcntrl   = 1'b0;
    jrcntrl  = 1'b0;
    jalcntrl = 1'b0;
    alu_zero = 1'b0;
    alu_neg  = 1'b0;
    rs_data  = 32'd0;
  endtask

  // Leaves the unit in IDLE, one cycle after the reset edge.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_ctrl();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Fetch 'word' (ready held high), apply the controls in EXEC for
  // stall_cycles stalled cycles plus the retiring one, return pc afterwards.
  task automatic run_instr(input logic [31:0] word, input logic [2:0] br,
                           input logic j, input logic jr, input logic jal,
                           input logic z, input logic n, input logic [31:0] rs,
                           input int stall_cycles, output logic [31:0] pc_after);
    int waited;
    imem_rdata = word;
    imem_ready = 1'b1;
    clear_ctrl();
    waited = 0;
    while (instr_valid !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL exec_timeout: got no instr_valid expected instr_valid within 50 cycles");
    end
    branch   = br;
    jcntrl   = j;
    jrcntrl  = jr;
    jalcntrl = jal;
    alu_zero = z;
    alu_neg  = n;
    rs_data  = rs;
    stall    = 1'b1;
    repeat (stall_cycles) begin
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(posedge clk); #1;
    pc_after = pc;
    clear_ctrl();
  endtask

  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] p;
    run_instr(32'h0300_0008, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, target, 0, p);
    chk("goto_pc", p, target);
  endtask

  // Branch-taken truth table, one nibble per code, indexed by {neg, zero}.
  logic [3:0] taken_tbl [1:6];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] p;
    logic [31:0] p0;
    logic [31:0] addrs [$];
    int          vcount;
    int          wcount;

    taken_tbl[1] = 4'b1010;  // beq
    taken_tbl[2] = 4'b0101;  // bne
    taken_tbl[3] = 4'b0011;  // bgez
    taken_tbl[4] = 4'b0001;  // bgtz
    taken_tbl[5] = 4'b1110;  // blez
    taken_tbl[6] = 4'b1100;  // bltz

    rst        = 1'b1;
    imem_ready = 1'b1;
    imem_rdata = 32'd0;
    clear_ctrl();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, then back-to-back nops with memory always ready.
    chk("rst_pc",          pc,          RST_PC);
    chk("rst_imem_req",    imem_req,    32'd0);
    chk("rst_instr_valid", instr_valid, 32'd0);
    chk("rst_halted",      halted,      32'd0);
    chk("rst_fault",       fault,       32'd0);
    chk("rst_instr",       instr,       32'd0);
    vcount = 0;
    wcount = 0;
    for (int c = 0; c < 7; c++) begin
      if (imem_req === 1'b1) addrs.push_back(imem_addr);
      vcount += int'(instr_valid === 1'b1);
      wcount += int'(pc_write === 1'b1);
      @(posedge clk); #1;
    end
    chk("boot_nreq",   32'(addrs.size()), 32'd3);
    if (addrs.size() == 3) begin
      chk("boot_addr0", addrs[0], 32'h0000_0040);
      chk("boot_addr1", addrs[1], 32'h0000_0044);
      chk("boot_addr2", addrs[2], 32'h0000_0048);
    end
    chk("boot_valid_cycles", 32'(vcount), 32'd3);
    chk("boot_write_cycles", 32'(wcount), 32'd3);

    // Branch table around pc 0x100 with offset -8.
    for (int code = 1; code <= 6; code++) begin
      for (int zn = 0; zn < 4; zn++) begin
        goto_pc(32'h0000_0100);
        run_instr(32'h1022_FFFE, 3'(code), 1'b0, 1'b0, 1'b0,
                  1'(zn & 1), 1'(zn >> 1), 32'd0, 0, p);
        chk($sformatf("branch_c%0d_zn%0d", code, zn), p,
            taken_tbl[code][zn] ? 32'h0000_00FC : 32'h0000_0104);
      end
    end

    // jal into a 256MB region, then jr overriding a simultaneous jump.
    goto_pc(32'h3000_0010);
    chk("jal_link_addr", link_addr, 32'h3000_0014);
    run_instr(32'h0C00_0100, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 0, p);
    chk("jal_target", p, 32'h3000_0400);
    run_instr(32'h0C00_0100, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
              32'h3000_0014, 0, p);
    chk("jr_priority", p, 32'h3000_0014);

    // Wrap: 0xFFFF_FFFC + 4 -> 0.
    goto_pc(32'hFFFF_FFFC);
    run_instr(32'h0000_0000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, p);
    chk("pc_wrap", p, 32'h0000_0000);

    // Three wait states in FETCH.
    p0         = pc;
    imem_ready = 1'b0;
    imem_rdata = 32'h0000_1234;
    for (int c = 0; c < 3; c++) begin
      chk("wait_imem_req",    imem_req,    32'd1);
      chk("wait_imem_addr",   imem_addr,   p0);
      chk("wait_instr_valid", instr_valid, 32'd0);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    chk("wait_exec_valid", instr_valid, 32'd1);
    chk("wait_exec_instr", instr,       32'h0000_1234);

    // Stall together with halt_req: stall wins, halt lands on release.
    stall    = 1'b1;
    halt_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("stall_pc_hold",   pc,          p0);
      chk("stall_valid",     instr_valid, 32'd1);
      chk("stall_no_halt",   halted,      32'd0);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    clear_ctrl();
    chk("halt_pc",       pc,          p0 + 32'd4);
    chk("halt_halted",   halted,      32'd1);
    chk("halt_imem_req", imem_req,    32'd0);
    chk("halt_valid",    instr_valid, 32'd0);
    imem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("halt_stays",     halted,   32'd1);
    chk("halt_stays_req", imem_req, 32'd0);

    // Reset in the middle of a fetch.
    do_reset();
    goto_pc(32'h0000_0500);
    imem_ready = 1'b0;
    chk("midfetch_req", imem_req, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midfetch_pc",    pc,          RST_PC);
    chk("midfetch_req0",  imem_req,    32'd0);
    chk("midfetch_instr", instr,       32'd0);
    chk("midfetch_valid", instr_valid, 32'd0);
    @(posedge clk); #1;
    chk("midfetch_refetch", imem_req, 32'd1);
    chk("midfetch_addr",    imem_addr, RST_PC);

    // Misaligned jr.
    goto_pc(32'h0000_0200);
    run_instr(32'h0300_0008, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
              32'h0000_0102, 0, p);
`ifdef JR_ALIGN_CHECK_EN
    chk("jr_misalign_pc",     p,      32'h0000_0200);
    chk("jr_misalign_fault",  fault,  32'd1);
    chk("jr_misalign_halted", halted, 32'd1);
`else
    chk("jr_misalign_pc",     p,      32'h0000_0102);
    chk("jr_misalign_fault",  fault,  32'd0);
    chk("jr_misalign_halted", halted, 32'd0);
`endif

    // Randomized phase; the model checks every cycle.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 199) == 0) ||
                   (halted === 1'b1 && $urandom_range(0, 7) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      imem_rdata = $urandom;
      stall      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 39) == 0);
      branch     = 3'($urandom_range(0, 7));
      jcntrl     = ($urandom_range(0, 5) == 0);
      jalcntrl   = jcntrl && ($urandom_range(0, 1) == 0);
      jrcntrl    = ($urandom_range(0, 7) == 0);
      alu_zero   = 1'($urandom_range(0, 1));
      alu_neg    = 1'($urandom_range(0, 1));
      rs_data    = $urandom;
      if ($urandom_range(0, 2) != 0) rs_data[1:0] = 2'b00;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_ctrl();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch and next-PC stage directly upstream of the main decoder.
- Holds the PC and fetches each instruction over a wait-state instruction-memory handshake.
- Presents the latched instruction to the decoder and datapath for one execute window.
- Resolves the next PC from the decoder's branch code (3-bit), jump, jr and jal controls plus ALU zero/sign flags, and supplies the jal link address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  32  fetch address, equals pc
imem_ready  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction, to decoder/datapath
instr_valid  out  1  instr is executing this cycle
stall  in  1  hold the current instruction in execute
halt_req  in  1  enter HALT after the current instruction retires
branch  in  3  decoder branch code: 001 beq, 010 bne, 011 bgez, 100 bgtz, 101 blez, 110 bltz
jcntrl  in  1  j or jal
jrcntrl  in  1  jr
jalcntrl  in  1  jal
alu_zero  in  1  ALU result == 0
alu_neg  in  1  ALU result[31]
rs_data  in  32  register rs value (jr target)
pc  out  32  current PC
link_addr  out  32  pc+4, written to $31 on jal
pc_write  out  1  pc updates at this clock edge
halted  out  1  unit is in HALT
fault  out  1  misaligned jr detected (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-fetch):
  - state<=IDLE, pc<=RESET_PC, instr<=0.
  - Outputs: imem_req=0, instr_valid=0, pc_write=0, halted=0, fault=0.
- States:
  - IDLE: one cycle after reset, then FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready=1: instr<=imem_rdata, next state EXEC. Otherwise hold, with no limit on wait states.
  - EXEC: instr_valid=1, imem_req=0.
    - stall=1: stay in EXEC; pc and instr hold; pc_write=0.
    - stall=0: pc_write=1 and pc<=next_pc; next state is HALT if halt_req=1, else FETCH.
  - HALT: imem_req=0, instr_valid=0, halted=1. Exited only by rst.
- Minimum cost is 2 cycles per instruction (FETCH with imem_ready high + EXEC).
- pc_write is combinational: high only in EXEC with stall=0.
- link_addr = pc + 4, combinational, valid in every state. jalcntrl only qualifies its use downstream; the unit does no extra work for jal beyond the jump itself.
- next_pc priority, highest first:
  1. jrcntrl=1: rs_data
  2. jcntrl=1: {pc_plus4[31:28], instr[25:0], 2'b00}
  3. branch taken: pc_plus4 + (sign_extend(instr[15:0]) << 2)
  4. otherwise: pc_plus4
- Branch taken conditions:
  - 001: alu_zero
  - 010: !alu_zero
  - 011: !alu_neg
  - 100: !alu_neg & !alu_zero
  - 101: alu_neg | alu_zero
  - 110: alu_neg
  - 000 and 111: never taken
- Arithmetic: all adds are 32-bit modulo 2^32; pc 32'hFFFF_FFFC + 4 wraps to 0. There is no overflow detection.
- Flags (alu_zero, alu_neg) and control inputs are sampled only in EXEC; they are don't-care elsewhere.
- Simultaneous stall and halt_req: stall wins. halt_req takes effect at the first non-stalled EXEC edge.
- halt_req outside EXEC is ignored.

Optional Feature:
- Macro JR_ALIGN_CHECK_EN.
- Defined: in EXEC with jrcntrl=1 and rs_data[1:0]!=0:
  - The instruction does not retire: pc holds, pc_write=0.
  - fault<=1 (sticky until rst) and next state is HALT, regardless of stall.
- Undefined: fault is tied 0. rs_data is loaded into pc unmodified, low bits included.

Test Plan:
- Reset with RESET_PC=32'h0000_0040, imem_ready tied 1 -> imem_addr sequence 0x40, 0x44, 0x48; instr_valid high every 2nd cycle; pc_write pulses 1 cycle each.
- imem_ready held low 3 cycles in FETCH -> imem_req stays 1, addr stable, instr_valid 0; EXEC on cycle after ready.
- pc=0x100, instr=beq with imm 16'hFFFE:
  - alu_zero=1 -> next pc 0xFC.
  - alu_zero=0 -> 0x104.
  - Repeat with bgtz/blez/bltz/bgez across all four (zero, neg) combinations, each matching the table.
- pc=0x3000_0010, instr=jal target 26'h0000100 -> link_addr=0x3000_0014, next pc 0x3000_0400. Then jr rs_data=0x3000_0014 with jcntrl also high -> next pc 0x3000_0014 (jr priority).
- stall=1 for 2 EXEC cycles together with halt_req=1 -> pc holds, instr_valid held; on stall release pc updates once, halted=1, imem_req stays 0. rst mid-FETCH -> pc=RESET_PC, IDLE.
- With JR_ALIGN_CHECK_EN: jr rs_data=0x0000_0102 -> fault=1, halted=1, pc unchanged. Without the macro -> pc=0x0000_0102, fault=0.
